// File: rtl/mod_arith_pkg.sv
// rtl/mod_arith_pkg.sv - shared constants and state encoding for the modular arithmetic blocks
package mod_arith_pkg;

  // Default operand/modulus width for the TSS datapath
  localparam int WIDTH_DEFAULT = 256;

  // secp256k1 field prime
  localparam logic [255:0] P_SECP256K1 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  // Controller states, same encoding as mod_inv
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_CALC  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/mod_mul_if.sv
// rtl/mod_mul_if.sv - operand/result handshake bundle for mod_mul
interface mod_mul_if #(
  parameter int WIDTH = 256
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] p;
  logic             start;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output a, b, p, start,
    input  out, busy, done, error
  );

  modport slave (
    input  a, b, p, start,
    output out, busy, done, error
  );

endinterface

// File: rtl/mod_dbl_add.sv
// rtl/mod_dbl_add.sv - one MSB-first double-and-add step modulo p
module mod_dbl_add #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] r_o
);

  // Inputs satisfy r_i < p_i and a_i < p_i, so each partial result stays
  // below 2*p_i and one conditional subtract restores the range.
  logic [WIDTH:0] pw;
  logic [WIDTH:0] dbl;
  logic [WIDTH:0] dbl_red;
  logic [WIDTH:0] sum;

  // Double, reduce, optionally add a, reduce again
  always_comb begin
    pw      = {1'b0, p_i};
    dbl     = {r_i, 1'b0};
    dbl_red = (dbl >= pw) ? (dbl - pw) : dbl;
    sum     = bit_i ? (dbl_red + {1'b0, a_i}) : dbl_red;
    r_o     = WIDTH'((sum >= pw) ? (sum - pw) : sum);
  end

endmodule

// File: rtl/mod_mul.sv
// rtl/mod_mul.sv - sequential modular multiplier, out = a*b mod p
module mod_mul
  import mod_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic      clk,
  input logic      rst,
  mod_mul_if.slave bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic             start_q;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] r_step;
  logic             accept;

  assign bus.out   = out_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.error = error_q;

  // Only a fresh rising edge of start while idle launches an operation
  assign accept = bus.start && !start_q && (state_q == ST_IDLE);

  mod_dbl_add #(.WIDTH(WIDTH)) u_step (
    .r_i   (r_q),
    .a_i   (a_q),
    .p_i   (p_q),
    .bit_i (b_q[idx_q]),
    .r_o   (r_step)
  );

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    r_d     = r_q;
    idx_d   = idx_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = bus.a;
          b_d     = bus.b;
          p_d     = bus.p;
          busy_d  = 1'b1;
          out_d   = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Operands must already be reduced so every step keeps r < p
        if ((p_q < WIDTH'(2)) || (a_q >= p_q) || (b_q >= p_q)) begin
          state_d = ST_ERR;
        end else begin
          r_d     = '0;
          idx_d   = IW'(WIDTH - 1);
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        r_d = r_step;
        if (idx_q == '0) begin
          out_d   = r_step;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        out_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      r_q     <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= bus.start;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

endmodule
